// File: rtl/level_exit_sequencer.sv
// -----------------------------------------------------------------------------
// level_exit_sequencer
//
// Watches the player sprite against the door (level 1) or the idol (level 2)
// that the placement block has positioned. The exit is reachable only once the
// enemies are cleared. The player must overlap the object on DWELL_FRAMES
// consecutive frames before anything happens. A door starts a level transit
// that lasts TRANSIT_FRAMES frames and then selects level 2. The idol sets a
// win flag that stays set until reset. State only changes on startOfFrame.
//
// Optional build macro: LEVEL_SKIP_EN
//   When defined, adds input skip_req. A rising edge on skip_req while in
//   LOCKED/OPEN/DWELL forces TRANSIT on the next startOfFrame.
//
// Ports:
//   clk, resetN          clock; asynchronous active-low reset
//   startOfFrame         one-cycle pulse per video frame (evaluation strobe)
//   enemies_cleared      high when no enemies remain
//   player_dead          high while the player death sequence runs
//   player_topLeftX/Y    player sprite position (11 bits)
//   obj_topLeftX/Y       door/idol position from the placement block
//   obj_is_idol          0 = door, 1 = idol
//   skip_req             (LEVEL_SKIP_EN only) level-skip request
//   level_select         current level, always 1 or 2
//   door_open            object reachable (enemies cleared, not in transit)
//   level_done           high while in transit
//   game_won             sticky win flag
// -----------------------------------------------------------------------------
module level_exit_sequencer #(
    parameter int PLAYER_W       = 32,
    parameter int OBJ_W          = 32,
    parameter int DWELL_FRAMES   = 8,
    parameter int TRANSIT_FRAMES = 60
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        startOfFrame,
    input  logic        enemies_cleared,
    input  logic        player_dead,
    input  logic [10:0] player_topLeftX,
    input  logic [10:0] player_topLeftY,
    input  logic [10:0] obj_topLeftX,
    input  logic [10:0] obj_topLeftY,
    input  logic        obj_is_idol,
`ifdef LEVEL_SKIP_EN
    input  logic        skip_req,
`endif
    output logic [1:0]  level_select,
    output logic        door_open,
    output logic        level_done,
    output logic        game_won
);

    typedef enum logic [2:0] {
        ST_LOCKED,
        ST_OPEN,
        ST_DWELL,
        ST_TRANSIT,
        ST_WON
    } state_e;

    localparam int DW = $clog2(DWELL_FRAMES + 1);
    localparam int TW = (TRANSIT_FRAMES > 1) ? $clog2(TRANSIT_FRAMES) : 1;
    localparam logic [DW-1:0] DWELL_LAST   = DW'(DWELL_FRAMES);
    localparam logic [TW-1:0] TRANSIT_LAST = TW'(TRANSIT_FRAMES - 1);

    state_e        state_q, state_d;
    logic [DW-1:0] dwell_cnt_q, dwell_cnt_d;
    logic [TW-1:0] transit_cnt_q, transit_cnt_d;
    logic [1:0]    level_select_q, level_select_d;
    logic          door_open_q, door_open_d;
    logic          level_done_q, level_done_d;
    logic          game_won_q, game_won_d;

    // Bounding-box overlap. The compare is widened to 12 bits so that
    // position + width near the right/bottom edge cannot wrap to a small value.
    logic [11:0] px, py, ox, oy;
    logic        overlap;

    always_comb begin
        px = {1'b0, player_topLeftX};
        py = {1'b0, player_topLeftY};
        ox = {1'b0, obj_topLeftX};
        oy = {1'b0, obj_topLeftY};
        overlap = (px < ox + 12'(OBJ_W)) && (ox < px + 12'(PLAYER_W)) &&
                  (py < oy + 12'(OBJ_W)) && (oy < py + 12'(PLAYER_W));
    end

    logic skip_fire;

`ifdef LEVEL_SKIP_EN
    // A skip edge can arrive between frame strobes, so it is held pending
    // until the next startOfFrame. The pending flag is dropped if the FSM
    // leaves the states where a skip is allowed.
    logic skip_q, skip_d;
    logic skip_pend_q, skip_pend_d;
    logic skip_active, skip_pend_now;

    always_comb begin
        skip_d        = skip_req;
        skip_active   = (state_q == ST_LOCKED) || (state_q == ST_OPEN) ||
                        (state_q == ST_DWELL);
        skip_pend_now = skip_pend_q || (skip_req && !skip_q);
        skip_fire     = startOfFrame && skip_active && skip_pend_now;
        skip_pend_d   = skip_active && skip_pend_now && !startOfFrame;
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            skip_q      <= 1'b0;
            skip_pend_q <= 1'b0;
        end else begin
            skip_q      <= skip_d;
            skip_pend_q <= skip_pend_d;
        end
    end
`else
    assign skip_fire = 1'b0;
`endif

    always_comb begin
        // NOTE: every signal assigned here gets a default first, so a branch that
        // skips an assignment holds the registered value instead of inferring a latch.
        state_d        = state_q;
        dwell_cnt_d    = dwell_cnt_q;
        transit_cnt_d  = transit_cnt_q;
        level_select_d = level_select_q;

        if (startOfFrame) begin
            case (state_q)
                ST_LOCKED, ST_OPEN, ST_DWELL: begin
                    if (skip_fire) begin
                        state_d       = ST_TRANSIT;
                        dwell_cnt_d   = '0;
                        transit_cnt_d = '0;
                    end else if (player_dead) begin
                        state_d     = ST_LOCKED;
                        dwell_cnt_d = '0;
                    end else if (state_q == ST_LOCKED) begin
                        if (enemies_cleared) state_d = ST_OPEN;
                    end else if (overlap && (dwell_cnt_q + DW'(1) == DWELL_LAST)) begin
                        // Dwell completion wins over enemies_cleared dropping
                        // on the same frame. obj_is_idol matters only here.
                        dwell_cnt_d   = '0;
                        transit_cnt_d = '0;
                        state_d       = obj_is_idol ? ST_WON : ST_TRANSIT;
                    end else if (!enemies_cleared) begin
                        state_d     = ST_LOCKED;
                        dwell_cnt_d = '0;
                    end else if (overlap) begin
                        state_d     = ST_DWELL;
                        dwell_cnt_d = dwell_cnt_q + DW'(1);
                    end else begin
                        state_d     = ST_OPEN;
                        dwell_cnt_d = '0;
                    end
                end
                ST_TRANSIT: begin
                    if (transit_cnt_q == TRANSIT_LAST) begin
                        // Level 2 is the last level; a transit from it stays there.
                        state_d        = ST_LOCKED;
                        transit_cnt_d  = '0;
                        level_select_d = 2'd2;
                    end else begin
                        transit_cnt_d = transit_cnt_q + TW'(1);
                    end
                end
                ST_WON: ;
                default: state_d = ST_LOCKED;
            endcase
        end

        // Outputs are decoded from the next state so the flops below present
        // them in the same cycle the state register updates.
        door_open_d  = (state_d == ST_OPEN) || (state_d == ST_DWELL);
        level_done_d = (state_d == ST_TRANSIT);
        game_won_d   = (state_d == ST_WON);
    end

    // NOTE: sequential state uses non-blocking assignments so that every flop
    // samples the pre-edge values, whatever order the simulator runs the blocks in.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q        <= ST_LOCKED;
            dwell_cnt_q    <= '0;
            transit_cnt_q  <= '0;
            level_select_q <= 2'd1;
            door_open_q    <= 1'b0;
            level_done_q   <= 1'b0;
            game_won_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            dwell_cnt_q    <= dwell_cnt_d;
            transit_cnt_q  <= transit_cnt_d;
            level_select_q <= level_select_d;
            door_open_q    <= door_open_d;
            level_done_q   <= level_done_d;
            game_won_q     <= game_won_d;
        end
    end

    assign level_select = level_select_q;
    assign door_open    = door_open_q;
    assign level_done   = level_done_q;
    assign game_won     = game_won_q;

endmodule

// File: tb/tb_level_exit_sequencer.sv
// -----------------------------------------------------------------------------
// tb_level_exit_sequencer
//
// Directed bench for level_exit_sequencer with default parameters
// (32x32 sprites, 8 dwell frames, 60 transit frames). Per-frame vectors with
// hand-computed expected outputs drive the level-1 sequence. Hand-written
// sequences cover the transits, the idol win, and reset in the middle of a
// transit.
// -----------------------------------------------------------------------------
module tb_level_exit_sequencer;

    logic        clk = 1'b0;
    logic        resetN = 1'b0;
    logic        startOfFrame = 1'b0;
    logic        enemies_cleared = 1'b0;
    logic        player_dead = 1'b0;
    logic [10:0] player_topLeftX = '0;
    logic [10:0] player_topLeftY = '0;
    logic [10:0] obj_topLeftX = '0;
    logic [10:0] obj_topLeftY = '0;
    logic        obj_is_idol = 1'b0;
    logic [1:0]  level_select;
    logic        door_open;
    logic        level_done;
    logic        game_won;
`ifdef LEVEL_SKIP_EN
    logic        skip_req = 1'b0;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    level_exit_sequencer dut (
        .clk             (clk),
        .resetN          (resetN),
        .startOfFrame    (startOfFrame),
        .enemies_cleared (enemies_cleared),
        .player_dead     (player_dead),
        .player_topLeftX (player_topLeftX),
        .player_topLeftY (player_topLeftY),
        .obj_topLeftX    (obj_topLeftX),
        .obj_topLeftY    (obj_topLeftY),
        .obj_is_idol     (obj_is_idol),
`ifdef LEVEL_SKIP_EN
        .skip_req        (skip_req),
`endif
        .level_select    (level_select),
        .door_open       (door_open),
        .level_done      (level_done),
        .game_won        (game_won)
    );

    typedef struct packed {
        logic        ec;
        logic        dead;
        logic        idol;
        logic [10:0] px;
        logic [10:0] py;
        logic [10:0] ox;
        logic [10:0] oy;
        logic [1:0]  lvl;
        logic        door;
        logic        done;
        logic        won;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic ec, input logic dead, input logic idol,
                       input logic [10:0] ax, input logic [10:0] ay,
                       input logic [10:0] bx, input logic [10:0] by,
                       input logic [1:0] lvl, input logic door,
                       input logic done, input logic won);
        vec_t v;
        v.ec = ec;   v.dead = dead; v.idol = idol;
        v.px = ax;   v.py = ay;     v.ox = bx;     v.oy = by;
        v.lvl = lvl; v.door = door; v.done = done; v.won = won;
        vecs.push_back(v);
    endtask

    task automatic set_pos(input logic [10:0] ax, input logic [10:0] ay,
                           input logic [10:0] bx, input logic [10:0] by);
        player_topLeftX = ax;
        player_topLeftY = ay;
        obj_topLeftX    = bx;
        obj_topLeftY    = by;
    endtask

    // One video frame: a single-cycle startOfFrame, then idle cycles.
    // Returns on a falling edge, away from the active edge.
    task automatic frame();
        @(negedge clk);
        startOfFrame = 1'b1;
        @(negedge clk);
        startOfFrame = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic expect_out(input string name, input logic [1:0] lvl,
                              input logic door, input logic done, input logic won);
        logic [4:0] act;
        logic [4:0] exp;
        act = {level_select, door_open, level_done, game_won};
        exp = {lvl, door, done, won};
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got lvl=%0d door=%0b done=%0b won=%0b, expected lvl=%0d door=%0b done=%0b won=%0b",
                     name, level_select, door_open, level_done, game_won,
                     lvl, door, done, won);
        end
    endtask

    task automatic run_frames(input int n, input string name, input logic [1:0] lvl,
                              input logic door, input logic done, input logic won);
        for (int i = 0; i < n; i++) begin
            frame();
            expect_out($sformatf("%s[%0d]", name, i), lvl, door, done, won);
        end
    endtask

    task automatic apply_reset(input string name);
        @(posedge clk);
        #3 resetN = 1'b0;
        #1 expect_out(name, 2'd1, 1'b0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        resetN = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        // Reset and reset values.
        repeat (3) @(negedge clk);
        expect_out("reset_held", 2'd1, 1'b0, 1'b0, 1'b0);
        resetN = 1'b1;
        @(negedge clk);
        expect_out("reset_released", 2'd1, 1'b0, 1'b0, 1'b0);

        // Without startOfFrame nothing may change, even with enemies cleared.
        enemies_cleared = 1'b1;
        repeat (6) @(negedge clk);
        expect_out("no_sof_hold", 2'd1, 1'b0, 1'b0, 1'b0);
        enemies_cleared = 1'b0;

        // Positions: A overlaps the door, FAR does not, E0 touches the door edge
        // (47+32 = 79, not < 79), E1 overlaps by one pixel, HI overlaps near
        // 2047 (2040+32 = 2072 needs 12 bits).
        for (int i = 0; i < 5; i++)
            add(1'b0, 1'b0, 1'b0, 11'd100, 11'd100, 11'd79, 11'd112, 2'd1, 1'b0, 1'b0, 1'b0);
        add(1'b1, 1'b0, 1'b0, 11'd500, 11'd500, 11'd79, 11'd112, 2'd1, 1'b1, 1'b0, 1'b0); // -> OPEN
        add(1'b1, 1'b0, 1'b0, 11'd47,  11'd100, 11'd79, 11'd100, 2'd1, 1'b1, 1'b0, 1'b0); // edge, stay OPEN
        add(1'b1, 1'b0, 1'b0, 11'd48,  11'd100, 11'd79, 11'd100, 2'd1, 1'b1, 1'b0, 1'b0); // DWELL, 1
        for (int i = 0; i < 6; i++)                                                      // DWELL, 2..7
            add(1'b1, 1'b0, 1'b0, 11'd100, 11'd100, 11'd79, 11'd112, 2'd1, 1'b1, 1'b0, 1'b0);
        add(1'b1, 1'b0, 1'b0, 11'd500, 11'd500, 11'd79, 11'd112, 2'd1, 1'b1, 1'b0, 1'b0); // broken -> OPEN
        for (int i = 0; i < 4; i++)                                                      // DWELL, 1..4
            add(1'b1, 1'b0, 1'b0, 11'd100, 11'd100, 11'd79, 11'd112, 2'd1, 1'b1, 1'b0, 1'b0);
        add(1'b1, 1'b1, 1'b0, 11'd100, 11'd100, 11'd79, 11'd112, 2'd1, 1'b0, 1'b0, 1'b0); // death on frame 5
        add(1'b1, 1'b0, 1'b0, 11'd100, 11'd100, 11'd79, 11'd112, 2'd1, 1'b1, 1'b0, 1'b0); // LOCKED -> OPEN
        for (int i = 0; i < 7; i++)                                                      // DWELL, 1..7
            add(1'b1, 1'b0, 1'b0, 11'd2030, 11'd2030, 11'd2040, 11'd2040, 2'd1, 1'b1, 1'b0, 1'b0);
        // 8th frame completes even though enemies_cleared drops on the same frame.
        add(1'b0, 1'b0, 1'b0, 11'd2030, 11'd2030, 11'd2040, 11'd2040, 2'd1, 1'b0, 1'b1, 1'b0);

        for (int i = 0; i < vecs.size(); i++) begin
            enemies_cleared = vecs[i].ec;
            player_dead     = vecs[i].dead;
            obj_is_idol     = vecs[i].idol;
            set_pos(vecs[i].px, vecs[i].py, vecs[i].ox, vecs[i].oy);
            frame();
            expect_out($sformatf("vec%0d", i), vecs[i].lvl, vecs[i].door,
                       vecs[i].done, vecs[i].won);
        end

        // Level-1 transit: 59 more frames high, the 60th switches to level 2.
        // player_dead and enemies_cleared are ignored during transit.
        player_dead     = 1'b1;
        enemies_cleared = 1'b1;
        run_frames(59, "transit1", 2'd1, 1'b0, 1'b1, 1'b0);
        frame();
        expect_out("transit1_exit", 2'd2, 1'b0, 1'b0, 1'b0);
        player_dead = 1'b0;

        // Level 2 with a door: obj_is_idol is high during the dwell but low on
        // the completing frame, so the result is a transit that stays on level 2.
        set_pos(11'd100, 11'd100, 11'd79, 11'd112);
        obj_is_idol = 1'b1;
        frame();
        expect_out("l2_open", 2'd2, 1'b1, 1'b0, 1'b0);
        run_frames(7, "l2_dwell", 2'd2, 1'b1, 1'b0, 1'b0);
        obj_is_idol = 1'b0;
        frame();
        expect_out("l2_transit_enter", 2'd2, 1'b0, 1'b1, 1'b0);
        run_frames(59, "transit2", 2'd2, 1'b0, 1'b1, 1'b0);
        frame();
        expect_out("transit2_exit", 2'd2, 1'b0, 1'b0, 1'b0);

        // Another level-2 transit, interrupted by reset, which returns to level 1.
        frame();
        expect_out("l2b_open", 2'd2, 1'b1, 1'b0, 1'b0);
        run_frames(7, "l2b_dwell", 2'd2, 1'b1, 1'b0, 1'b0);
        frame();
        expect_out("l2b_transit_enter", 2'd2, 1'b0, 1'b1, 1'b0);
        run_frames(20, "l2b_transit", 2'd2, 1'b0, 1'b1, 1'b0);
        apply_reset("reset_mid_transit");
        expect_out("after_reset_mid_transit", 2'd1, 1'b0, 1'b0, 1'b0);

        // Back to level 2 through the level-1 door.
        frame();
        expect_out("l1c_open", 2'd1, 1'b1, 1'b0, 1'b0);
        run_frames(7, "l1c_dwell", 2'd1, 1'b1, 1'b0, 1'b0);
        frame();
        expect_out("l1c_transit_enter", 2'd1, 1'b0, 1'b1, 1'b0);
        run_frames(59, "transit3", 2'd1, 1'b0, 1'b1, 1'b0);
        frame();
        expect_out("transit3_exit", 2'd2, 1'b0, 1'b0, 1'b0);

        // Idol pickup wins the game; the win is sticky until reset.
        obj_is_idol = 1'b1;
        frame();
        expect_out("idol_open", 2'd2, 1'b1, 1'b0, 1'b0);
        run_frames(7, "idol_dwell", 2'd2, 1'b1, 1'b0, 1'b0);
        frame();
        expect_out("idol_won", 2'd2, 1'b0, 1'b0, 1'b1);
        player_dead     = 1'b1;
        enemies_cleared = 1'b0;
        run_frames(3, "won_sticky", 2'd2, 1'b0, 1'b0, 1'b1);
        apply_reset("reset_after_win");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/level_exit_sequencer.md
Name: level_exit_sequencer

Overview:
Consumer of the door/idol placement block's outputs. It watches the player sprite against the placed object (door on level 1, idol on level 2) and gates the exit on enemies cleared. It requires a sustained overlap before advancing. It drives the level_select that the placement block and the bitmap mux consume, and flags the win.

Parameters:
PLAYER_W, 32, player sprite width/height in pixels
OBJ_W, 32, door/idol sprite width/height in pixels
DWELL_FRAMES, 8, consecutive overlapping frames required to trigger exit/pickup
TRANSIT_FRAMES, 60, frames level_done stays high before level switches

Ports:
clk  in  1  system clock
resetN  in  1  asynchronous active-low reset
startOfFrame  in  1  one-cycle pulse per video frame; all evaluation happens on it
enemies_cleared  in  1  level, high when no enemies remain
player_dead  in  1  level, high while player death sequence runs
player_topLeftX  in  11  player sprite X
player_topLeftY  in  11  player sprite Y
obj_topLeftX  in  11  door/idol X from placement block
obj_topLeftY  in  11  door/idol Y from placement block
obj_is_idol  in  1  bitmap select from placement block (0 door, 1 idol)
level_select  out  2  current level: 1 or 2
door_open  out  1  object is reachable (enemies cleared, not in transit)
level_done  out  1  high during TRANSIT
game_won  out  1  sticky win flag

Behaviour:
- Clock and reset: clk; resetN is asynchronous, active-low.
- Reset values: state LOCKED, level_select=1, door_open=0, level_done=0, game_won=0, dwell_cnt=0, transit_cnt=0.
- All outputs are registered.
- All state/counter updates occur only on cycles with startOfFrame=1, except reset.
- Overlap, combinational, 12-bit unsigned compare, no wrap:
  - {0,px} < ox+OBJ_W && ox < px+PLAYER_W
  - same test for Y.
  - Sums are computed at 12 bits, so coordinates near 2047 do not overflow.
- States:
  - LOCKED: door_open=0. Go to OPEN when enemies_cleared=1.
  - OPEN: door_open=1.
    - enemies_cleared=0 -> LOCKED.
    - overlap=1 -> DWELL with dwell_cnt=1.
  - DWELL: door_open=1.
    - overlap=1: dwell_cnt++.
    - overlap=0: -> OPEN, dwell_cnt=0.
    - Reaching dwell_cnt==DWELL_FRAMES:
      - obj_is_idol=0 -> TRANSIT, transit_cnt=0.
      - obj_is_idol=1 -> WON.
  - TRANSIT: level_done=1, door_open=0, transit_cnt++.
    - At transit_cnt==TRANSIT_FRAMES-1: level_select 1->2, level_done=0, -> LOCKED.
    - If level_select was already 2: stay at 2, -> LOCKED.
  - WON: game_won=1, door_open=0; terminal until reset.
- player_dead=1 on a frame, in LOCKED/OPEN/DWELL: -> LOCKED, dwell_cnt=0, level unchanged.
  - Ignored in TRANSIT and WON.
- Simultaneous events on the same frame:
  - player_dead outranks overlap/dwell completion.
  - Dwell completion outranks enemies_cleared falling.
- obj_is_idol is sampled only at dwell completion.
- Reset mid-TRANSIT returns to level 1 immediately.
- level_select never takes values 0 or 3.

Optional Feature:
LEVEL_SKIP_EN
- Defined: adds input skip_req (1 bit). A rising edge of skip_req, detected with an internal registered copy, in LOCKED/OPEN/DWELL forces TRANSIT on the next startOfFrame, regardless of enemies_cleared and overlap.
- Undefined: port absent; behaviour as above.

Test Plan:
- Reset, then 5 frames with enemies_cleared=0 and overlap present -> level_select=1, door_open=0, level_done=0 throughout.
- Setup: enemies_cleared=1; player (100,100); obj (79,112), obj_is_idol=0; 8 overlapping frames -> DWELL. On the 8th frame level_done=1 and stays high 60 frames; then level_select=2, door_open=0, state LOCKED.
- Overlap broken: same setup, overlap held 7 frames, player moved to (500,500) on frame 8 -> back to OPEN, level_done stays 0. Re-entry needs 8 fresh frames.
- Edge contact: player (47,100) with obj (79,100) gives 47+32=79, not <79, so no overlap. Player (48,100) -> overlap, dwell starts.
- Idol win: level 2, obj_is_idol=1, enemies_cleared=1, 8 overlap frames -> game_won=1, sticky. Later player_dead=1 and enemies_cleared=0 leave game_won=1. resetN low -> game_won=0, level_select=1.
- Death: player_dead=1 on dwell frame 5 -> LOCKED, dwell_cnt=0. With enemies_cleared still 1 -> OPEN on the next frame, and 8 new frames are required.
